// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and dmem-busy freeze.
// Latency: 1 cycle ID->EX; stall_pc/stall_ifid/flush_ifid are combinational in the same cycle.
// Backpressure: dmem_busy freezes ID/EX and stalls the front end; HAZARD_PERF_EN adds perf counters.
`ifndef RS_WIDTH
`define RS_WIDTH 5
`endif

module id_ex_hazard_reg #(
    parameter int XLEN = 32,
    parameter int RS_W = `RS_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_id,
    input  logic [RS_W-1:0] rs1_id,
    input  logic [RS_W-1:0] rs2_id,
    input  logic [RS_W-1:0] rd_id,
    input  logic            use_rs1_id,
    input  logic            use_rs2_id,
    input  logic [XLEN-1:0] rs1_data_id,
    input  logic [XLEN-1:0] rs2_data_id,
    input  logic [XLEN-1:0] imm_id,
    input  logic [XLEN-1:0] pc_id,
    input  logic            regwrite_id,
    input  logic            memread_id,
    input  logic            memwrite_id,
    input  logic            memtoreg_id,
    input  logic            alusrc_id,
    input  logic [3:0]      aluop_id,
    input  logic            branch_taken_ex,
    input  logic            dmem_busy,
    output logic            stall_pc,
    output logic            stall_ifid,
    output logic            flush_ifid,
    output logic            valid_ex,
    output logic [RS_W-1:0] rs1_ex,
    output logic [RS_W-1:0] rs2_ex,
    output logic [RS_W-1:0] rd_ex,
    output logic [XLEN-1:0] rs1_data_ex,
    output logic [XLEN-1:0] rs2_data_ex,
    output logic [XLEN-1:0] imm_ex,
    output logic [XLEN-1:0] pc_ex,
    output logic            regwrite_ex,
    output logic            memread_ex,
    output logic            memwrite_ex,
    output logic            memtoreg_ex,
    output logic            alusrc_ex,
    output logic [3:0]      aluop_ex
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]     loaduse_cnt,
    output logic [31:0]     flush_cnt
`endif
);

    typedef struct packed {
        logic            valid;
        logic [RS_W-1:0] rs1;
        logic [RS_W-1:0] rs2;
        logic [RS_W-1:0] rd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic            memtoreg;
        logic            alusrc;
        logic [3:0]      aluop;
    } idex_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        HOLD   = 2'd2
    } state_e;

    idex_t  ex_q, ex_d, id_pkt;
    state_e state_q, state_d;
    logic   lu, do_hold, do_flush, do_bubble;

    assign id_pkt = '{valid: valid_id, rs1: rs1_id, rs2: rs2_id, rd: rd_id,
                      rs1_data: rs1_data_id, rs2_data: rs2_data_id, imm: imm_id, pc: pc_id,
                      regwrite: regwrite_id, memread: memread_id, memwrite: memwrite_id,
                      memtoreg: memtoreg_id, alusrc: alusrc_id, aluop: aluop_id};

    // Load in EX whose destination is read by the instruction in ID; x0 never conflicts.
    assign lu = ex_q.valid && ex_q.memread && (ex_q.rd != '0) && valid_id &&
                ((use_rs1_id && (rs1_id == ex_q.rd)) || (use_rs2_id && (rs2_id == ex_q.rd)));

    assign do_hold   = dmem_busy;
    assign do_flush  = !dmem_busy && branch_taken_ex;
    assign do_bubble = !dmem_busy && !branch_taken_ex && lu;

    assign stall_pc   = rst && (do_hold || do_bubble);
    assign stall_ifid = rst && (do_hold || do_bubble);
    assign flush_ifid = rst && do_flush;

    always_comb begin
        ex_d = ex_q;
        if (do_hold) begin
            ex_d = ex_q;
        end else if (do_flush || do_bubble) begin
            ex_d = '0;
        end else begin
            ex_d = id_pkt;
        end
    end

    // State only tracks what happened; the datapath never looks at it.
    always_comb begin
        state_d = RUN;
        if (dmem_busy) begin
            state_d = HOLD;
        end else if (do_bubble) begin
            state_d = BUBBLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q    <= '0;
            state_q <= RUN;
        end else begin
            ex_q    <= ex_d;
            state_q <= state_d;
        end
    end

    assign valid_ex    = ex_q.valid;
    assign rs1_ex      = ex_q.rs1;
    assign rs2_ex      = ex_q.rs2;
    assign rd_ex       = ex_q.rd;
    assign rs1_data_ex = ex_q.rs1_data;
    assign rs2_data_ex = ex_q.rs2_data;
    assign imm_ex      = ex_q.imm;
    assign pc_ex       = ex_q.pc;
    assign regwrite_ex = ex_q.regwrite;
    assign memread_ex  = ex_q.memread;
    assign memwrite_ex = ex_q.memwrite;
    assign memtoreg_ex = ex_q.memtoreg;
    assign alusrc_ex   = ex_q.alusrc;
    assign aluop_ex    = ex_q.aluop;

`ifdef HAZARD_PERF_EN
    logic [31:0] loaduse_cnt_q, loaduse_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Saturating; busy cycles never reach the increment because do_bubble/do_flush exclude them.
    always_comb begin
        loaduse_cnt_d = loaduse_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        if (do_bubble && (loaduse_cnt_q != 32'hFFFF_FFFF)) begin
            loaduse_cnt_d = loaduse_cnt_q + 32'd1;
        end
        if (do_flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            loaduse_cnt_q <= '0;
            flush_cnt_q   <= '0;
        end else begin
            loaduse_cnt_q <= loaduse_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign loaduse_cnt = loaduse_cnt_q;
    assign flush_cnt   = flush_cnt_q;
`endif

endmodule

// File: doc/id_ex_hazard_reg.md
# id_ex_hazard_reg

ID/EX pipeline register with integrated hazard control for the 5-stage RISC-V pipeline. Captures decoded operands and control from ID and presents them to EX (including `rs1_ex`/`rs2_ex`, consumed by the EX forwarding unit). Detects load-use hazards and inserts a one-cycle bubble. Handles branch-taken flushes and holds the whole front end while data memory is busy.

## Interface
Parameters:
- XLEN, 32, datapath width
- RS_W, `RS_WIDTH (5), register index width

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous reset, active-low
- valid_id  in  1  ID holds a real instruction
- rs1_id, rs2_id, rd_id  in  RS_W  register indices from decode
- use_rs1_id, use_rs2_id  in  1  instruction actually reads rs1/rs2
- rs1_data_id, rs2_data_id, imm_id, pc_id  in  XLEN  operands from ID
- regwrite_id, memread_id, memwrite_id, memtoreg_id, alusrc_id  in  1  control
- aluop_id  in  4  ALU operation
- branch_taken_ex  in  1  EX resolved a taken branch/jump this cycle
- dmem_busy  in  1  data memory not ready; pipeline must freeze
- stall_pc  out  1  hold PC (combinational)
- stall_ifid  out  1  hold IF/ID register (combinational)
- flush_ifid  out  1  clear IF/ID register (combinational)
- valid_ex  out  1  EX holds a real instruction
- rs1_ex, rs2_ex, rd_ex  out  RS_W  registered indices
- rs1_data_ex, rs2_data_ex, imm_ex, pc_ex  out  XLEN  registered operands
- regwrite_ex, memread_ex, memwrite_ex, memtoreg_ex, alusrc_ex  out  1  registered control
- aluop_ex  out  4  registered ALU op
- loaduse_cnt, flush_cnt  out  32  perf counters (only with HAZARD_PERF_EN)

## Operation
- Load-use hazard (`lu`): valid_ex && memread_ex && rd_ex!=0 && valid_id && ((use_rs1_id && rs1_id==rd_ex) || (use_rs2_id && rs2_id==rd_ex)).
- Priority per cycle: dmem_busy > branch_taken_ex > lu > normal advance.
- Hold (dmem_busy=1):
  - All ID/EX registers keep their value.
  - stall_pc = stall_ifid = 1; flush_ifid = 0.
- Flush (branch_taken_ex=1, dmem_busy=0):
  - ID/EX loads a bubble; flush_ifid = 1; stall_pc = stall_ifid = 0; lu is ignored.
- Load-use (lu=1, no busy, no flush):
  - ID/EX loads a bubble; stall_pc = stall_ifid = 1.
  - Next cycle the load is in MEM, lu reevaluates false and the instruction advances; forwarding supplies the data.
- Normal: all *_ex registers load the *_id values; valid_ex = valid_id.
- Bubble: valid_ex, regwrite_ex, memread_ex and memwrite_ex cleared; aluop_ex=0; rd_ex=0, rs1_ex=0, rs2_ex=0. Data fields are don't-care and are cleared to 0.
- State machine (registered `state`):
  - RUN: default.
  - BUBBLE: entered after a load-use insertion; returns to RUN next cycle unless a new lu occurs.
  - HOLD: entered whenever dmem_busy=1 and left on the first cycle dmem_busy=0, returning to RUN.
  - State has no effect on the datapath beyond the rules above; it exists for perf counting and debug, and BUBBLE is never entered twice for the same load.

## Timing
- On reset assertion (async), every *_ex output, valid_ex and state are cleared: 0 / RUN. Counters reset to 0.
- Reset mid-stall drops the in-flight instruction; no replay.
- Capture latency: 1 cycle (ID values visible on *_ex after the next rising edge).
- stall_pc, stall_ifid and flush_ifid are combinational from the current inputs and registered state, valid in the same cycle.
- All three are 0 while rst is low.
- Simultaneous cases:
  - branch_taken_ex with lu: flush wins; no stall.
  - dmem_busy with branch_taken_ex: hold; the flush is taken the first cycle busy drops, since the branch is still in EX.
- rd_ex==0 never triggers lu.

## Configuration
- HAZARD_PERF_EN defined:
  - loaduse_cnt increments once per inserted load-use bubble.
  - flush_cnt increments once per flush cycle.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and are frozen during HOLD.
- Not defined: counters and the loaduse_cnt/flush_cnt ports are absent. All other behaviour is identical.

## Test plan
- Reset: hold rst=0 with random inputs -> all *_ex = 0, valid_ex = 0, stall/flush = 0. Release -> first edge captures ID values.
- Load-use: EX has lw x5 (memread_ex=1, rd_ex=5); ID has add reading rs1=5.
  - Cycle N: stall_pc = stall_ifid = 1; next edge: valid_ex = 0.
  - Cycle N+1: stall = 0; the add captured with rs1_ex = 5.
  - Same case with use_rs1_id=0 -> no stall.
- Branch flush with simultaneous lu: branch_taken_ex=1 -> flush_ifid = 1, stall = 0, next valid_ex = 0.
- dmem_busy for 3 cycles: *_ex unchanged; stall = 1 for exactly 3 cycles. Busy overlapping a branch -> flush asserted on the 4th cycle.
- rd_ex = 0 load with rs1_id = 0 -> no stall.
- With HAZARD_PERF_EN:
  - 2 load-use events and 1 flush -> loaduse_cnt = 2, flush_cnt = 1.
  - Preload a counter near saturation -> it holds at 0xFFFFFFFF.
